// File: rtl/control_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit:
// opcodes, ALU codes, state encoding, IR field layout and control word.
package control_pkg;

    localparam int OP_BITS = 5;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_SHR  = 5'b00100;
    localparam logic [4:0] OP_SHRA = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_ADDI = 5'b01001;
    localparam logic [4:0] OP_ANDI = 5'b01010;
    localparam logic [4:0] OP_ORI  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01100;
    localparam logic [4:0] OP_MUL  = 5'b01101;
    localparam logic [4:0] OP_NEG  = 5'b01110;
    localparam logic [4:0] OP_NOT  = 5'b01111;
    localparam logic [4:0] OP_LD   = 5'b10000;
    localparam logic [4:0] OP_LDI  = 5'b10001;
    localparam logic [4:0] OP_ST   = 5'b10010;
    localparam logic [4:0] OP_JAL  = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_BR   = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = OP_ADD;
    localparam logic [4:0] ALU_AND = OP_AND;
    localparam logic [4:0] ALU_OR  = OP_OR;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3,
        S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE, C_IMM, C_MULDIV, C_NEGNOT,
        C_LD, C_LDI, C_ST, C_BR,
        C_JR, C_JAL, C_IN, C_OUT,
        C_MFHI, C_MFLO, C_NOP, C_HALT
    } op_class_t;

    typedef struct packed {
        logic       run;
        logic       clear;
        logic [4:0] alu_op;
        logic       inc_pc;
        logic       hi_out;
        logic       lo_out;
        logic       zhi_out;
        logic       zlo_out;
        logic       pc_out;
        logic       mdr_out;
        logic       inport_out;
        logic       c_out;
        logic       ba_out;
        logic       r_out;
        logic       mar_in;
        logic       z_in;
        logic       pc_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       hi_in;
        logic       lo_in;
        logic       con_in;
        logic       outport_in;
        logic       r_in;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       mem_read;
        logic       mem_write;
    } ctrl_t;

    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t c;
        unique case (1'b1)
            op <= OP_ROL:                          c = C_RTYPE;
            op inside {OP_ADDI, OP_ANDI, OP_ORI}:  c = C_IMM;
            op inside {OP_MUL, OP_DIV}:            c = C_MULDIV;
            op inside {OP_NEG, OP_NOT}:            c = C_NEGNOT;
            op == OP_LD:                           c = C_LD;
            op == OP_LDI:                          c = C_LDI;
            op == OP_ST:                           c = C_ST;
            op == OP_BR:                           c = C_BR;
            op == OP_JR:                           c = C_JR;
            op == OP_JAL:                          c = C_JAL;
            op == OP_IN:                           c = C_IN;
            op == OP_OUT:                          c = C_OUT;
            op == OP_MFHI:                         c = C_MFHI;
            op == OP_MFLO:                         c = C_MFLO;
            op == OP_HALT:                         c = C_HALT;
            default:                               c = C_NOP;
        endcase
        return c;
    endfunction

    // Final execute step of each instruction class.
    function automatic state_t last_step(input op_class_t c);
        state_t s;
        case (c)
            C_RTYPE, C_IMM, C_LDI: s = S_T5;
            C_MULDIV, C_BR:        s = S_T6;
            C_NEGNOT, C_JAL:       s = S_T4;
            C_LD, C_ST:            s = S_T7;
            default:               s = S_T3;
        endcase
        return s;
    endfunction

    function automatic logic [4:0] alu_code(input logic [4:0] op);
        logic [4:0] a;
        case (op)
            OP_ADDI: a = ALU_ADD;
            OP_ANDI: a = ALU_AND;
            OP_ORI:  a = ALU_OR;
            default: a = op;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Moore output decoder: maps the current step and opcode class to
// the full datapath control word.
module control_decode
    import control_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] opcode,
    input  logic       con_ff_bit,
    output ctrl_t      ctrl
);

    op_class_t cls;

    assign cls = classify(opcode);

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_RESET: ctrl.clear = 1'b1;
            S_HALT: ctrl.run = 1'b0;
            S_T0: begin
                ctrl.run    = 1'b1;
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
                ctrl.z_in   = 1'b1;
                ctrl.alu_op = ALU_ADD;
            end
            S_T1: begin
                ctrl.run      = 1'b1;
                ctrl.zlo_out  = 1'b1;
                ctrl.pc_in    = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.mdr_in   = 1'b1;
            end
            S_T2: begin
                ctrl.run     = 1'b1;
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            default: begin
                ctrl.run = 1'b1;
                case (cls)
                    C_RTYPE, C_IMM: begin
                        case (state)
                            S_T3: begin
                                ctrl.grb   = 1'b1;
                                ctrl.r_out = 1'b1;
                                ctrl.y_in  = 1'b1;
                            end
                            S_T4: begin
                                ctrl.z_in   = 1'b1;
                                ctrl.alu_op = alu_code(opcode);
                                if (cls == C_IMM) begin
                                    ctrl.c_out = 1'b1;
                                end else begin
                                    ctrl.grc   = 1'b1;
                                    ctrl.r_out = 1'b1;
                                end
                            end
                            S_T5: begin
                                ctrl.zlo_out = 1'b1;
                                ctrl.gra     = 1'b1;
                                ctrl.r_in    = 1'b1;
                            end
                            default: ctrl.run = 1'b1;
                        endcase
                    end
                    C_MULDIV: begin
                        case (state)
                            S_T3: begin
                                ctrl.gra   = 1'b1;
                                ctrl.r_out = 1'b1;
                                ctrl.y_in  = 1'b1;
                            end
                            S_T4: begin
                                ctrl.grb    = 1'b1;
                                ctrl.r_out  = 1'b1;
                                ctrl.z_in   = 1'b1;
                                ctrl.alu_op = opcode;
                            end
                            S_T5: begin
                                ctrl.zlo_out = 1'b1;
                                ctrl.lo_in   = 1'b1;
                            end
                            S_T6: begin
                                ctrl.zhi_out = 1'b1;
                                ctrl.hi_in   = 1'b1;
                            end
                            default: ctrl.run = 1'b1;
                        endcase
                    end
                    C_NEGNOT: begin
                        if (state == S_T3) begin
                            ctrl.grb    = 1'b1;
                            ctrl.r_out  = 1'b1;
                            ctrl.z_in   = 1'b1;
                            ctrl.alu_op = opcode;
                        end else if (state == S_T4) begin
                            ctrl.zlo_out = 1'b1;
                            ctrl.gra     = 1'b1;
                            ctrl.r_in    = 1'b1;
                        end
                    end
                    C_LD, C_LDI, C_ST: begin
                        case (state)
                            S_T3: begin
                                ctrl.grb    = 1'b1;
                                ctrl.ba_out = 1'b1;
                                ctrl.y_in   = 1'b1;
                            end
                            S_T4: begin
                                ctrl.c_out  = 1'b1;
                                ctrl.z_in   = 1'b1;
                                ctrl.alu_op = ALU_ADD;
                            end
                            S_T5: begin
                                ctrl.zlo_out = 1'b1;
                                ctrl.mar_in  = (cls != C_LDI);
                                ctrl.gra     = (cls == C_LDI);
                                ctrl.r_in    = (cls == C_LDI);
                            end
                            S_T6: begin
                                ctrl.mem_read = (cls == C_LD);
                                ctrl.gra      = (cls == C_ST);
                                ctrl.r_out    = (cls == C_ST);
                                ctrl.mdr_in   = 1'b1;
                            end
                            S_T7: begin
                                ctrl.mdr_out   = (cls == C_LD);
                                ctrl.gra       = (cls == C_LD);
                                ctrl.r_in      = (cls == C_LD);
                                ctrl.mem_write = (cls == C_ST);
                            end
                            default: ctrl.run = 1'b1;
                        endcase
                    end
                    C_BR: begin
                        case (state)
                            S_T3: begin
                                ctrl.gra    = 1'b1;
                                ctrl.r_out  = 1'b1;
                                ctrl.con_in = 1'b1;
                            end
                            S_T4: begin
                                ctrl.pc_out = 1'b1;
                                ctrl.y_in   = 1'b1;
                            end
                            S_T5: begin
                                ctrl.c_out  = 1'b1;
                                ctrl.z_in   = 1'b1;
                                ctrl.alu_op = ALU_ADD;
                            end
                            S_T6: begin
                                ctrl.zlo_out = 1'b1;
                                ctrl.pc_in   = con_ff_bit;
                            end
                            default: ctrl.run = 1'b1;
                        endcase
                    end
                    C_JR: begin
                        ctrl.gra   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.pc_in = 1'b1;
                    end
                    C_JAL: begin
                        // Link first (Rb <- PC), then jump to Ra.
                        if (state == S_T3) begin
                            ctrl.pc_out = 1'b1;
                            ctrl.grb    = 1'b1;
                            ctrl.r_in   = 1'b1;
                        end else begin
                            ctrl.gra   = 1'b1;
                            ctrl.r_out = 1'b1;
                            ctrl.pc_in = 1'b1;
                        end
                    end
                    C_IN: begin
                        ctrl.inport_out = 1'b1;
                        ctrl.gra        = 1'b1;
                        ctrl.r_in       = 1'b1;
                    end
                    C_OUT: begin
                        ctrl.gra        = 1'b1;
                        ctrl.r_out      = 1'b1;
                        ctrl.outport_in = 1'b1;
                    end
                    C_MFHI, C_MFLO: begin
                        ctrl.hi_out = (cls == C_MFHI);
                        ctrl.lo_out = (cls == C_MFLO);
                        ctrl.gra    = 1'b1;
                        ctrl.r_in   = 1'b1;
                    end
                    default: ctrl.run = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/control.sv
// Mini SRC control unit top: step register, stop latch and
// mapping of the decoded control word onto the datapath strobes.
module control
    import control_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stop,
    input  logic                  Interupts,
    input  logic [DATA_WIDTH-1:0] IR,
    input  logic                  con_ff_bit,
    output logic                  run,
    output logic                  clear,
    output logic [4:0]            ALU_opcode,
    output logic                  IncPC,
    output logic                  HIout,
    output logic                  LOout,
    output logic                  Zhi_out,
    output logic                  Zlo_out,
    output logic                  PCout,
    output logic                  MDRout,
    output logic                  Inport_out,
    output logic                  Cout,
    output logic                  BAout,
    output logic                  Rout,
    output logic                  MARin,
    output logic                  Zin,
    output logic                  PCin,
    output logic                  MDRin,
    output logic                  IRin,
    output logic                  Yin,
    output logic                  HIin,
    output logic                  LOin,
    output logic                  CONin,
    output logic                  outport_in,
    output logic                  Rin,
    output logic                  Gra,
    output logic                  Grb,
    output logic                  Grc,
    output logic                  Mem_Read,
    output logic                  Mem_Write,
    output logic                  Mem_enable512x32
);

    state_t     state;
    state_t     state_n;
    logic       stop_seen;
    logic       stop_seen_n;
    logic       stop_now;
    logic [4:0] opcode;
    op_class_t  cls;
    state_t     last;
    ctrl_t      ctrl;
    logic       unused_inputs;

    assign opcode        = IR[DATA_WIDTH-1 -: OP_BITS];
    assign cls           = classify(opcode);
    assign last          = last_step(cls);
    assign stop_now      = stop_seen | stop;
    assign unused_inputs = ^{Interupts, IR[DATA_WIDTH-OP_BITS-1:0]};

    always_comb begin
        state_n     = state;
        stop_seen_n = stop_seen;
        unique case (state)
            S_RESET: state_n = S_T0;
            S_HALT:  state_n = S_HALT;
            default: begin
                if (state == S_T3 && cls == C_HALT) begin
                    state_n = S_HALT;
                end else if (state == last) begin
                    state_n = stop_now ? S_HALT : S_T0;
                end else begin
                    state_n = state_t'(state + 4'd1);
                end
                // A stop seen anywhere in the instruction is held until it ends.
                stop_seen_n = (state_n == S_T0) ? 1'b0 : stop_now;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RESET;
            stop_seen <= 1'b0;
        end else begin
            state     <= state_n;
            stop_seen <= stop_seen_n;
        end
    end

    control_decode u_decode (
        .state      (state),
        .opcode     (opcode),
        .con_ff_bit (con_ff_bit),
        .ctrl       (ctrl)
    );

    assign run              = ctrl.run;
    assign clear            = ctrl.clear;
    assign ALU_opcode       = ctrl.alu_op;
    assign IncPC            = ctrl.inc_pc;
    assign HIout            = ctrl.hi_out;
    assign LOout            = ctrl.lo_out;
    assign Zhi_out          = ctrl.zhi_out;
    assign Zlo_out          = ctrl.zlo_out;
    assign PCout            = ctrl.pc_out;
    assign MDRout           = ctrl.mdr_out;
    assign Inport_out       = ctrl.inport_out;
    assign Cout             = ctrl.c_out;
    assign BAout            = ctrl.ba_out;
    assign Rout             = ctrl.r_out;
    assign MARin            = ctrl.mar_in;
    assign Zin              = ctrl.z_in;
    assign PCin             = ctrl.pc_in;
    assign MDRin            = ctrl.mdr_in;
    assign IRin             = ctrl.ir_in;
    assign Yin              = ctrl.y_in;
    assign HIin             = ctrl.hi_in;
    assign LOin             = ctrl.lo_in;
    assign CONin            = ctrl.con_in;
    assign outport_in       = ctrl.outport_in;
    assign Rin              = ctrl.r_in;
    assign Gra              = ctrl.gra;
    assign Grb              = ctrl.grb;
    assign Grc              = ctrl.grc;
    assign Mem_Read         = ctrl.mem_read;
    assign Mem_Write        = ctrl.mem_write;
    assign Mem_enable512x32 = ctrl.mem_read | ctrl.mem_write;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for the Mini SRC control unit: directed scenarios
// plus random instruction streams against a step-table reference model.
module tb_control;

    typedef logic [34:0] vec_t;

    localparam logic [29:0] INCPC  = 30'h1 << 0;
    localparam logic [29:0] HIOUT  = 30'h1 << 1;
    localparam logic [29:0] LOOUT  = 30'h1 << 2;
    localparam logic [29:0] ZHI    = 30'h1 << 3;
    localparam logic [29:0] ZLO    = 30'h1 << 4;
    localparam logic [29:0] PCOUT  = 30'h1 << 5;
    localparam logic [29:0] MDROUT = 30'h1 << 6;
    localparam logic [29:0] INPORT = 30'h1 << 7;
    localparam logic [29:0] COUT   = 30'h1 << 8;
    localparam logic [29:0] BAOUT  = 30'h1 << 9;
    localparam logic [29:0] ROUT   = 30'h1 << 10;
    localparam logic [29:0] MARIN  = 30'h1 << 11;
    localparam logic [29:0] ZIN    = 30'h1 << 12;
    localparam logic [29:0] PCIN   = 30'h1 << 13;
    localparam logic [29:0] MDRIN  = 30'h1 << 14;
    localparam logic [29:0] IRIN   = 30'h1 << 15;
    localparam logic [29:0] YIN    = 30'h1 << 16;
    localparam logic [29:0] HIIN   = 30'h1 << 17;
    localparam logic [29:0] LOIN   = 30'h1 << 18;
    localparam logic [29:0] CONIN  = 30'h1 << 19;
    localparam logic [29:0] OUTIN  = 30'h1 << 20;
    localparam logic [29:0] RIN    = 30'h1 << 21;
    localparam logic [29:0] GRA    = 30'h1 << 22;
    localparam logic [29:0] GRB    = 30'h1 << 23;
    localparam logic [29:0] GRC    = 30'h1 << 24;
    localparam logic [29:0] MRD    = 30'h1 << 25;
    localparam logic [29:0] MWR    = 30'h1 << 26;
    localparam logic [29:0] MEN    = 30'h1 << 27;
    localparam logic [29:0] RUN    = 30'h1 << 28;
    localparam logic [29:0] CLEAR  = 30'h1 << 29;

    localparam vec_t V_RESET = {5'd0, CLEAR};
    localparam vec_t V_HALT  = '0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stop = 1'b0;
    logic Interupts = 1'b0;
    logic [31:0] IR = '0;
    logic con_ff_bit = 1'b0;
    logic run, clear, IncPC, HIout, LOout, Zhi_out, Zlo_out, PCout;
    logic MDRout, Inport_out, Cout, BAout, Rout, MARin, Zin, PCin;
    logic MDRin, IRin, Yin, HIin, LOin, CONin, outport_in, Rin;
    logic Gra, Grb, Grc, Mem_Read, Mem_Write, Mem_enable512x32;
    logic [4:0] ALU_opcode;

    int vectors = 0;
    int miscompares = 0;
    vec_t trace [0:9];
    int tlen;

    always #5 clk = ~clk;

    control #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .stop(stop), .Interupts(Interupts),
        .IR(IR), .con_ff_bit(con_ff_bit), .run(run), .clear(clear),
        .ALU_opcode(ALU_opcode), .IncPC(IncPC), .HIout(HIout),
        .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
        .PCout(PCout), .MDRout(MDRout), .Inport_out(Inport_out),
        .Cout(Cout), .BAout(BAout), .Rout(Rout), .MARin(MARin),
        .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .CONin(CONin), .outport_in(outport_in),
        .Rin(Rin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Mem_Read(Mem_Read),
        .Mem_Write(Mem_Write), .Mem_enable512x32(Mem_enable512x32)
    );

    function automatic vec_t obs();
        return {ALU_opcode, clear, run, Mem_enable512x32, Mem_Write,
                Mem_Read, Grc, Grb, Gra, Rin, outport_in, CONin, LOin,
                HIin, Yin, IRin, MDRin, PCin, Zin, MARin, Rout, BAout,
                Cout, Inport_out, MDRout, PCout, Zlo_out, Zhi_out, LOout,
                HIout, IncPC};
    endfunction

    // Number of execute steps per opcode.
    function automatic int n_exec(logic [4:0] op);
        if (op <= 5'd8) return 3;
        case (op)
            5'd9, 5'd10, 5'd11: return 3;
            5'd12, 5'd13:       return 4;
            5'd14, 5'd15:       return 2;
            5'd16:              return 5;
            5'd17:              return 3;
            5'd18:              return 5;
            5'd19:              return 2;
            5'd21:              return 4;
            default:            return 1;
        endcase
    endfunction

    // Expected outputs in step s (0..2 fetch, 3.. execute).
    function automatic vec_t exp_vec(logic [4:0] op, int s, bit con);
        logic [29:0] m;
        logic [4:0] a;
        int e;
        m = RUN;
        a = 5'd0;
        e = s - 3;
        if (s == 0) m |= PCOUT | MARIN | INCPC | ZIN;
        else if (s == 1) m |= ZLO | PCIN | MRD | MEN | MDRIN;
        else if (s == 2) m |= MDROUT | IRIN;
        else if (op <= 5'd11) begin
            if (e == 0) m |= GRB | ROUT | YIN;
            if (e == 1 && op <= 5'd8) begin m |= GRC | ROUT | ZIN; a = op; end
            if (e == 1 && op > 5'd8) begin
                m |= COUT | ZIN;
                a = (op == 5'd9) ? 5'd0 : (op == 5'd10) ? 5'd2 : 5'd3;
            end
            if (e == 2) m |= ZLO | GRA | RIN;
        end else if (op == 5'd12 || op == 5'd13) begin
            if (e == 0) m |= GRA | ROUT | YIN;
            if (e == 1) begin m |= GRB | ROUT | ZIN; a = op; end
            if (e == 2) m |= ZLO | LOIN;
            if (e == 3) m |= ZHI | HIIN;
        end else if (op == 5'd14 || op == 5'd15) begin
            if (e == 0) begin m |= GRB | ROUT | ZIN; a = op; end
            if (e == 1) m |= ZLO | GRA | RIN;
        end else if (op >= 5'd16 && op <= 5'd18) begin
            if (e == 0) m |= GRB | BAOUT | YIN;
            if (e == 1) m |= COUT | ZIN;
            if (e == 2) m |= (op == 5'd17) ? (ZLO | GRA | RIN) : (ZLO | MARIN);
            if (e == 3) m |= (op == 5'd16) ? (MRD | MEN | MDRIN) : (GRA | ROUT | MDRIN);
            if (e == 4) m |= (op == 5'd16) ? (MDROUT | GRA | RIN) : (MWR | MEN);
        end else if (op == 5'd19) begin
            m |= (e == 0) ? (PCOUT | GRB | RIN) : (GRA | ROUT | PCIN);
        end else if (op == 5'd20) m |= GRA | ROUT | PCIN;
        else if (op == 5'd21) begin
            if (e == 0) m |= GRA | ROUT | CONIN;
            if (e == 1) m |= PCOUT | YIN;
            if (e == 2) m |= COUT | ZIN;
            if (e == 3) m |= ZLO | (con ? PCIN : 30'h0);
        end else if (op == 5'd22) m |= INPORT | GRA | RIN;
        else if (op == 5'd23) m |= GRA | ROUT | OUTIN;
        else if (op == 5'd24) m |= HIOUT | GRA | RIN;
        else if (op == 5'd25) m |= LOOUT | GRA | RIN;
        return {a, m};
    endfunction

    // Drive one instruction from T0 and record every step plus the one after.
    task automatic capture(input logic [31:0] ir, input bit con, input int stop_at);
        IR = ir;
        con_ff_bit = con;
        tlen = 3 + n_exec(ir[31:27]);
        for (int s = 0; s <= tlen; s++) begin
            trace[s] = obs();
            if (s == stop_at) stop = 1'b1;
            if (s < tlen) begin
                @(posedge clk);
                #1;
                stop = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (obs() !== V_RESET) begin
                miscompares++;
                $display("FAIL reset_hold%0d got %h want %h", i, obs(), V_RESET);
            end
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (obs() !== exp_vec(5'd0, 0, 1'b0)) begin
            miscompares++;
            $display("FAIL reset_t0 got %h want %h", obs(), exp_vec(5'd0, 0, 1'b0));
        end
    endtask

    task automatic test_ror();
        logic [31:0] ir;
        ir = 32'b00111_0011_0010_0000_000000000000011;
        capture(ir, 1'b0, -1);
        vectors++;
        if (tlen != 6 || trace[4][34:30] !== 5'b00111) begin
            miscompares++;
            $display("FAIL ror_len_alu got %0d/%b want 6/00111", tlen, trace[4][34:30]);
        end
        for (int s = 0; s < tlen; s++) begin
            vectors++;
            if (trace[s] !== exp_vec(5'd7, s, 1'b0)) begin
                miscompares++;
                $display("FAIL ror_T%0d got %h want %h", s, trace[s], exp_vec(5'd7, s, 1'b0));
            end
        end
        vectors++;
        if (trace[tlen] !== exp_vec(5'd0, 0, 1'b0)) begin
            miscompares++;
            $display("FAIL ror_next got %h want T0", trace[tlen]);
        end
    endtask

    task automatic test_mul();
        capture({5'b01101, 27'h1234567}, 1'b0, -1);
        vectors++;
        if (tlen != 7 || !trace[5][18] || !trace[6][17] || !trace[6][3]) begin
            miscompares++;
            $display("FAIL mul_lohi got len %0d T5 %h T6 %h want len 7 LOin/HIin/Zhi", tlen, trace[5], trace[6]);
        end
        for (int s = 0; s < tlen; s++) begin
            vectors++;
            if (trace[s] !== exp_vec(5'd13, s, 1'b0)) begin
                miscompares++;
                $display("FAIL mul_T%0d got %h want %h", s, trace[s], exp_vec(5'd13, s, 1'b0));
            end
        end
        vectors++;
        if (trace[tlen] !== exp_vec(5'd0, 0, 1'b0)) begin
            miscompares++;
            $display("FAIL mul_next got %h want T0", trace[tlen]);
        end
    endtask

    task automatic test_branch();
        for (int c = 0; c < 2; c++) begin
            capture({5'b10101, 27'h0abcdef}, c[0], -1);
            vectors++;
            if (trace[6][13] !== c[0]) begin
                miscompares++;
                $display("FAIL br_pcin_con%0d got %b want %b", c, trace[6][13], c[0]);
            end
            for (int s = 0; s <= tlen; s++) begin
                vectors++;
                if (trace[s] !== exp_vec(s == tlen ? 5'd0 : 5'd21, s == tlen ? 0 : s, c[0])) begin
                    miscompares++;
                    $display("FAIL br_con%0d_T%0d got %h", c, s, trace[s]);
                end
            end
        end
    endtask

    task automatic test_ld_st();
        capture({5'b10000, 27'h0011111}, 1'b0, -1);
        vectors++;
        if (trace[6][25] !== 1'b1 || trace[6][27] !== 1'b1 || trace[7][27] !== 1'b0) begin
            miscompares++;
            $display("FAIL ld_memread got T6 %h T7 %h", trace[6], trace[7]);
        end
        for (int s = 0; s < tlen; s++) begin
            vectors++;
            if (trace[s] !== exp_vec(5'd16, s, 1'b0)) begin
                miscompares++;
                $display("FAIL ld_T%0d got %h want %h", s, trace[s], exp_vec(5'd16, s, 1'b0));
            end
        end
        capture({5'b10010, 27'h0022222}, 1'b0, -1);
        vectors++;
        if (trace[7][26] !== 1'b1 || trace[7][27] !== 1'b1 || trace[6][27] !== 1'b0) begin
            miscompares++;
            $display("FAIL st_memwrite got T6 %h T7 %h", trace[6], trace[7]);
        end
        for (int s = 0; s <= tlen; s++) begin
            vectors++;
            if (trace[s] !== exp_vec(s == tlen ? 5'd0 : 5'd18, s == tlen ? 0 : s, 1'b0)) begin
                miscompares++;
                $display("FAIL st_T%0d got %h", s, trace[s]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] ir;
        bit con;
        for (int i = 0; i < 60; i++) begin
            ir = $urandom;
            if (ir[31:27] == 5'd27) ir[31:27] = 5'd26;
            con = 1'($urandom_range(0, 1));
            capture(ir, con, -1);
            for (int s = 0; s <= tlen; s++) begin
                vectors++;
                if (trace[s] !== exp_vec(s == tlen ? 5'd0 : ir[31:27], s == tlen ? 0 : s, con)) begin
                    miscompares++;
                    $display("FAIL rand%0d op%0d T%0d got %h want %h", i, ir[31:27], s, trace[s],
                             exp_vec(s == tlen ? 5'd0 : ir[31:27], s == tlen ? 0 : s, con));
                end
            end
        end
    endtask

    task automatic recover(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (obs() !== V_RESET) begin
            miscompares++;
            $display("FAIL %s_reset got %h want %h", tag, obs(), V_RESET);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (obs() !== exp_vec(5'd0, 0, 1'b0)) begin
            miscompares++;
            $display("FAIL %s_t0 got %h want T0", tag, obs());
        end
    endtask

    task automatic test_halt_op();
        capture({5'b11011, 27'h5555555}, 1'b0, -1);
        vectors++;
        if (trace[3] !== {5'd0, RUN} || trace[4] !== V_HALT) begin
            miscompares++;
            $display("FAIL halt_op got T3 %h next %h", trace[3], trace[4]);
        end
        recover("halt_op");
    endtask

    task automatic test_stop();
        capture({5'b00000, 27'h0123456}, 1'b0, 3);
        for (int s = 0; s < tlen; s++) begin
            vectors++;
            if (trace[s] !== exp_vec(5'd0, s, 1'b0)) begin
                miscompares++;
                $display("FAIL stop_add_T%0d got %h want %h", s, trace[s], exp_vec(5'd0, s, 1'b0));
            end
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs() !== V_HALT) begin
                miscompares++;
                $display("FAIL stop_halt%0d got %h want %h", i, obs(), V_HALT);
            end
            @(posedge clk);
            #1;
        end
        recover("stop");
        capture({5'b11010, 27'h0}, 1'b0, -1);
        vectors++;
        if (trace[tlen] !== exp_vec(5'd0, 0, 1'b0)) begin
            miscompares++;
            $display("FAIL stop_cleared got %h want T0", trace[tlen]);
        end
    endtask

    task automatic test_reset_abort();
        IR = {5'b10000, 27'h0};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if (obs() !== exp_vec(5'd16, 4, 1'b0)) begin
            miscompares++;
            $display("FAIL abort_T4 got %h want %h", obs(), exp_vec(5'd16, 4, 1'b0));
        end
        recover("abort");
    endtask

    initial begin
        test_reset();
        test_ror();
        test_mul();
        test_branch();
        test_ld_st();
        test_random();
        test_halt_op();
        test_stop();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
